sipo_deser: RTL and testbench

- Downstream partner of the team's 4-bit parallel-in/serial-out shift register.
- Takes the serial stream, which arrives LSB first (bit 0 first, as produced by a right-shift serializer), plus a per-bit enable and a start-of-frame marker.
- Reassembles each WIDTH-bit word.
- Presents each word on a one-entry valid/ready output register, with resync and overrun detection.

---
 rtl/sipo_pkg.sv | 23 ++
 rtl/sipo_deser_if.sv | 34 +++
 rtl/sipo_out_reg.sv | 56 +++++
 rtl/sipo_deser.sv | 96 +++++++++
 tb/tb_sipo_deser.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sipo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sipo_pkg
// Description : Shared types and constants for the serial-in/parallel-out
//               deserializer.
// Revision    : 1.0 - initial release
// ============================================================================
package sipo_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Bit-counter width able to hold the value WIDTH itself.
    function automatic int cw_of(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sipo_deser_if.sv
`default_nettype none
// ============================================================================
// Module      : sipo_deser_if
// Description : Serial input and valid/ready word output bundle of the
//               deserializer.
// Revision    : 1.0 - initial release
// ============================================================================
interface sipo_deser_if
    import sipo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             si;
    logic             bit_en;
    logic             sof;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;
    logic             resync;
    logic             overrun;
    logic             ovr_clr;

    modport master (
        output si, bit_en, sof, dout_ready, ovr_clr,
        input  dout, dout_valid, busy, resync, overrun
    );

    modport slave (
        input  si, bit_en, sof, dout_ready, ovr_clr,
        output dout, dout_valid, busy, resync, overrun
    );
endinterface
`default_nettype wire

// File: rtl/sipo_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : sipo_out_reg
// Description : One-entry valid/ready holding register with sticky overrun.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_out_reg
    import sipo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_word_valid,
    input  wire logic [WIDTH-1:0] i_word,
    input  wire logic             i_ready,
    input  wire logic             i_ovr_clr,
    output logic      [WIDTH-1:0] o_dout,
    output logic                  o_valid,
    output logic                  o_overrun
);
    logic [WIDTH-1:0] r_dout;
    logic             r_valid;
    logic             r_overrun;
    logic             w_drop;

    assign w_drop = i_word_valid && r_valid && !i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (i_word_valid) begin
                if (!r_valid || i_ready) begin
                    r_dout  <= i_word;
                    r_valid <= 1'b1;
                end
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
            // A drop in the same cycle as a clear must stay visible.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (i_ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_dout    = r_dout;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;
endmodule
`default_nettype wire

// File: rtl/sipo_deser.sv
`default_nettype none
// ============================================================================
// Module      : sipo_deser
// Description : LSB-first serial-to-parallel deserializer with frame resync
//               and a one-entry valid/ready output register.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_deser
    import sipo_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CW    = cw_of(WIDTH)
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    sipo_deser_if.slave bus
);
    localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_count;
    logic             r_resync;
    logic [WIDTH-1:0] w_shifted;
    logic             w_done;

    generate
        if (WIDTH == 1) begin : g_w1
            assign w_shifted = bus.si;
        end else begin : g_wn
            assign w_shifted = {bus.si, r_sr[WIDTH-1:1]};
        end
    endgenerate

    // A sof on the final bit restarts the frame instead of completing it.
    assign w_done = bus.bit_en &&
                    ((r_state == IDLE  && bus.sof && WIDTH == 1) ||
                     (r_state == SHIFT && !bus.sof && r_count == c_last));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_sr     <= '0;
            r_count  <= '0;
            r_resync <= 1'b0;
        end else begin
            r_resync <= 1'b0;
            if (bus.bit_en) begin
                case (r_state)
                    IDLE: begin
                        if (bus.sof) begin
                            r_sr <= w_shifted;
                            if (WIDTH == 1) begin
                                r_count <= '0;
                            end else begin
                                r_count <= CW'(1);
                                r_state <= SHIFT;
                            end
                        end
                    end
                    SHIFT: begin
                        r_sr <= w_shifted;
                        if (bus.sof) begin
                            r_count  <= CW'(1);
                            r_resync <= 1'b1;
                        end else if (r_count == c_last) begin
                            r_count <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_count <= r_count + CW'(1);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy   = (r_state == SHIFT);
    assign bus.resync = r_resync;

    sipo_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_word_valid (w_done),
        .i_word       (w_shifted),
        .i_ready      (bus.dout_ready),
        .i_ovr_clr    (bus.ovr_clr),
        .o_dout       (bus.dout),
        .o_valid      (bus.dout_valid),
        .o_overrun    (bus.overrun)
    );
endmodule
`default_nettype wire

// File: tb/tb_sipo_deser.sv
`default_nettype none
// ============================================================================
// Module      : tb_sipo_deser
// Description : Scoreboard bench for sipo_deser with a frame-level reference
//               model, directed scenarios and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_deser;
    import sipo_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sipo_deser_if #(.WIDTH(W)) bus ();

    sipo_deser #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frames as lists of bits, output as a one-word buffer.
    int              m_bits[$];
    bit              m_busy, m_valid, m_ovr, m_resync;
    logic [W-1:0]    exp_q[$];
    bit              mdl_done, mdl_drop;
    int              mdl_word;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_bits.delete();
            exp_q.delete();
            m_busy   = 0;
            m_valid  = 0;
            m_ovr    = 0;
            m_resync = 0;
        end else begin
            mdl_done = 0;
            mdl_word = 0;
            m_resync = 0;
            if (bus.bit_en) begin
                if (bus.sof) begin
                    if (m_busy) m_resync = 1;
                    m_bits.delete();
                    m_bits.push_back(int'(bus.si));
                    m_busy = 1;
                end else if (m_busy) begin
                    m_bits.push_back(int'(bus.si));
                end
                if (m_busy && m_bits.size() == W) begin
                    mdl_done = 1;
                    for (int i = 0; i < W; i++) mdl_word += m_bits[i] * (2 ** i);
                    m_bits.delete();
                    m_busy = 0;
                end
            end
            mdl_drop = mdl_done && m_valid && !bus.dout_ready;
            if (mdl_done) begin
                if (!m_valid || bus.dout_ready) begin
                    exp_q.push_back(W'(mdl_word));
                    m_valid = 1;
                end
            end else if (m_valid && bus.dout_ready) begin
                m_valid = 0;
            end
            if (mdl_drop) m_ovr = 1;
            else if (bus.ovr_clr) m_ovr = 0;
        end
    end

    // Monitor: status every cycle, word compared when it is handed over.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("dout_valid", 32'(bus.dout_valid), 32'(m_valid));
            chk("busy",       32'(bus.busy),       32'(m_busy));
            chk("resync",     32'(bus.resync),     32'(m_resync));
            chk("overrun",    32'(bus.overrun),    32'(m_ovr));
            if (bus.dout_valid && bus.dout_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 32'(bus.dout), 32'hFFFF_FFFF);
                end else begin
                    chk("dout_word", 32'(bus.dout), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic step(input bit en, input bit s, input bit f);
        bus.bit_en = en;
        bus.si     = s;
        bus.sof    = f;
        @(posedge clk);
        #1;
        bus.bit_en = 1'b0;
        bus.sof    = 1'b0;
    endtask

    task automatic frame(input logic [W-1:0] v, input int gap_after, input int gap_len,
                         input bit rdy_last, input bit clr_last);
        logic sv_rdy;
        sv_rdy = bus.dout_ready;
        for (int i = 0; i < W; i++) begin
            if (i == W - 1) begin
                if (rdy_last) bus.dout_ready = 1'b1;
                if (clr_last) bus.ovr_clr = 1'b1;
            end
            step(1'b1, v[i], i == 0);
            if (i == gap_after) begin
                for (int g = 0; g < gap_len; g++) step(1'b0, 1'b0, 1'b0);
            end
        end
        bus.dout_ready = sv_rdy;
        bus.ovr_clr    = 1'b0;
    endtask

    task automatic drain();
        bus.dout_ready = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b0);
        bus.dout_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] p;
        bus.si = 0; bus.bit_en = 0; bus.sof = 0; bus.dout_ready = 0; bus.ovr_clr = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout",    32'(bus.dout),       32'h0);
        chk("rst_valid",   32'(bus.dout_valid), 32'h0);
        chk("rst_busy",    32'(bus.busy),       32'h0);
        chk("rst_overrun", 32'(bus.overrun),    32'h0);
        rst_n = 1'b1;

        // Reset in the middle of a frame
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk("mid_busy", 32'(bus.busy), 32'h1);
        rst_n = 1'b0;
        #2;
        chk("mrst_busy",   32'(bus.busy),       32'h0);
        chk("mrst_valid",  32'(bus.dout_valid), 32'h0);
        chk("mrst_resync", 32'(bus.resync),     32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        frame(4'hD, -1, 0, 1'b0, 1'b0);
        chk("t1_valid", 32'(bus.dout_valid), 32'h1);
        chk("t1_dout",  32'(bus.dout),       32'hD);
        drain();

        // Gapped bits under backpressure
        frame(4'h9, 1, 3, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("t2_hold", 32'(bus.dout), 32'h9);
        bus.dout_ready = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        bus.dout_ready = 1'b0;
        chk("t2_released", 32'(bus.dout_valid), 32'h0);

        // Back-to-back with accept on the completing cycle
        frame(4'hD, -1, 0, 1'b0, 1'b0);
        frame(4'h9, -1, 0, 1'b1, 1'b0);
        chk("t3_dout",    32'(bus.dout),       32'h9);
        chk("t3_valid",   32'(bus.dout_valid), 32'h1);
        chk("t3_overrun", 32'(bus.overrun),    32'h0);
        drain();

        // Overrun, clear, and set-over-clear priority
        frame(4'h3, -1, 0, 1'b0, 1'b0);
        frame(4'hC, -1, 0, 1'b0, 1'b0);
        chk("t4_dout", 32'(bus.dout),    32'h3);
        chk("t4_ovr",  32'(bus.overrun), 32'h1);
        bus.ovr_clr = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        bus.ovr_clr = 1'b0;
        chk("t4_clr", 32'(bus.overrun), 32'h0);
        frame(4'hC, -1, 0, 1'b0, 1'b1);
        chk("t4_set_prio", 32'(bus.overrun), 32'h1);
        drain();
        bus.ovr_clr = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        bus.ovr_clr = 1'b0;

        // Resync discards the partial word
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk("t5_pulse", 32'(bus.resync), 32'h1);
        step(1'b1, 1'b1, 1'b0);
        chk("t5_pulse_end", 32'(bus.resync), 32'h0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("t5_dout", 32'(bus.dout), 32'hE);
        drain();

        // Loopback from a right-shifting 4-bit serializer
        bus.dout_ready = 1'b1;
        p = 4'b1101;
        for (int i = 0; i < W; i++) begin
            step(1'b1, p[0], i == 0);
            p = p >> 1;
        end
        chk("t6_first", 32'(bus.dout), 32'hD);
        p = 4'b1001;
        for (int i = 0; i < W; i++) begin
            step(1'b1, p[0], i == 0);
            p = p >> 1;
        end
        chk("t6_second", 32'(bus.dout), 32'h9);
        bus.dout_ready = 1'b0;
        drain();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bus.dout_ready = ($urandom_range(0, 1) == 1);
            bus.ovr_clr    = ($urandom_range(0, 9) == 0);
            step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom_range(0, 6) == 0);
        end
        bus.ovr_clr = 1'b0;
        drain();
        chk("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
